// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY,
      ARB_RESP
   } arb_state_e;

   typedef enum logic {
      PORT_F,
      PORT_D
   } arb_port_e;

   localparam int unsigned WDOG_W = 8;

endpackage

// File: rtl/arb_pick.sv
// Combinational two-way pick between fetch (F) and load/store (D) requests.
module arb_pick
   import mem_arbiter_pkg::*;
#(
   parameter bit D_PRIO = 1'b0
) (
   input  logic      f_req,
   input  logic      d_req,
   input  arb_port_e last_gnt,
   output logic      grant_valid,
   output arb_port_e grant_port
);

   // Select a port: a lone requester wins; a conflict goes to D or alternates.
   always_comb begin
      grant_valid = f_req | d_req;
      grant_port  = PORT_F;
      if (f_req && d_req) begin
         if (D_PRIO) begin
            grant_port = PORT_D;
         end else begin
            grant_port = (last_gnt == PORT_F) ? PORT_D : PORT_F;
         end
      end else if (d_req) begin
         grant_port = PORT_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Memory-port arbiter: grants F or D, runs one access with a watchdog, returns a one-cycle ack.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255,
   parameter bit          D_PRIO  = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_ack,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              bus_err
);

   localparam bit                WDOG_EN   = (TIMEOUT != 0);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

   arb_state_e        state;
   arb_port_e         last_gnt;
   arb_port_e         gnt_port;
   logic              wr_q;
   logic [WDOG_W-1:0] wdog;

   logic              grant_valid;
   arb_port_e         grant_port;
   logic              sel_wr;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              timeout_hit;
   logic [DATA_W-1:0] resp_data;

   arb_pick #(
      .D_PRIO(D_PRIO)
   ) u_pick (
      .f_req      (f_req),
      .d_req      (d_req),
      .last_gnt   (last_gnt),
      .grant_valid(grant_valid),
      .grant_port (grant_port)
   );

   // Route the winning requester's command toward the grant registers.
   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = f_addr;
      sel_wdata = '0;
      if (grant_port == PORT_D) begin
         sel_wr    = d_wr;
         sel_addr  = d_addr;
         sel_wdata = d_wdata;
      end
   end

   // Abort condition and the data returned on completion (zero when aborted).
   always_comb begin
      timeout_hit = WDOG_EN && (wdog == WDOG_LAST);
      resp_data   = mem_ready ? mem_rdata : '0;
   end

   // Arbiter FSM; ack/bus_err are set on the BUSY->RESP edge so they are high during RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ARB_IDLE;
         last_gnt  <= PORT_D;
         gnt_port  <= PORT_F;
         wr_q      <= 1'b0;
         wdog      <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         f_ack     <= 1'b0;
         d_ack     <= 1'b0;
         f_rdata   <= '0;
         d_rdata   <= '0;
         bus_err   <= 1'b0;
      end else begin
         f_ack   <= 1'b0;
         d_ack   <= 1'b0;
         bus_err <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (grant_valid) begin
                  gnt_port  <= grant_port;
                  last_gnt  <= grant_port;
                  wr_q      <= sel_wr;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_rd    <= ~sel_wr;
                  mem_wr    <= sel_wr;
                  wdog      <= '0;
                  state     <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (mem_ready || timeout_hit) begin
                  mem_rd  <= 1'b0;
                  mem_wr  <= 1'b0;
                  bus_err <= ~mem_ready;
                  state   <= ARB_RESP;
                  if (gnt_port == PORT_F) begin
                     f_ack   <= 1'b1;
                     f_rdata <= resp_data;
                  end else begin
                     d_ack <= 1'b1;
                     if (!wr_q) begin
                        d_rdata <= resp_data;
                     end
                  end
               end else if (wdog != '1) begin
                  wdog <= wdog + 1'b1;
               end
            end
            ARB_RESP: begin
               state <= ARB_IDLE;
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: u0 is round-robin with TIMEOUT=4, u1 is D-priority with no watchdog.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        f_req;
   logic [15:0] f_addr;
   logic        d_req;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   logic        f_ack0, d_ack0, mem_rd0, mem_wr0, bus_err0;
   logic [31:0] f_rdata0, d_rdata0, mem_wdata0;
   logic [15:0] mem_addr0;
   logic        f_ack1, d_ack1, mem_rd1, mem_wr1, bus_err1;
   logic [31:0] f_rdata1, d_rdata1, mem_wdata1;
   logic [15:0] mem_addr1;

   int total;
   int bad;

   mem_arbiter #(
      .ADDR_W (16),
      .DATA_W (32),
      .TIMEOUT(4),
      .D_PRIO (1'b0)
   ) u0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .f_req    (f_req),
      .f_addr   (f_addr),
      .f_ack    (f_ack0),
      .f_rdata  (f_rdata0),
      .d_req    (d_req),
      .d_wr     (d_wr),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_ack    (d_ack0),
      .d_rdata  (d_rdata0),
      .mem_rd   (mem_rd0),
      .mem_wr   (mem_wr0),
      .mem_addr (mem_addr0),
      .mem_wdata(mem_wdata0),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .bus_err  (bus_err0)
   );

   mem_arbiter #(
      .ADDR_W (16),
      .DATA_W (32),
      .TIMEOUT(0),
      .D_PRIO (1'b1)
   ) u1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .f_req    (f_req),
      .f_addr   (f_addr),
      .f_ack    (f_ack1),
      .f_rdata  (f_rdata1),
      .d_req    (d_req),
      .d_wr     (d_wr),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_ack    (d_ack1),
      .d_rdata  (d_rdata1),
      .mem_rd   (mem_rd1),
      .mem_wr   (mem_wr1),
      .mem_addr (mem_addr1),
      .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .bus_err  (bus_err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench did not finish");
   end

   initial begin
      logic [3:0]  exp_d0;
      logic [15:0] exp_addr;
      logic [31:0] rd;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      f_req = 1'b0; f_addr = '0;
      d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
      mem_rdata = '0; mem_ready = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_mem_rd0", 64'(mem_rd0), 64'd0);
      chk("rst_mem_wr0", 64'(mem_wr0), 64'd0);
      chk("rst_acks0",   64'({f_ack0, d_ack0, bus_err0}), 64'd0);
      chk("rst_addr0",   64'(mem_addr0), 64'd0);
      chk("rst_rdata0",  64'({f_rdata0, d_rdata0}), 64'd0);
      chk("rst_strb1",   64'({mem_rd1, mem_wr1, f_ack1, d_ack1, bus_err1}), 64'd0);
      rst_n = 1'b1;
      tick();

      // F read, ready in the second strobe cycle
      f_req = 1'b1; f_addr = 16'h0010;
      tick();
      chk("f_rd_c1",    64'(mem_rd0), 64'd1);
      chk("f_addr",     64'(mem_addr0), 64'h0010);
      chk("f_noack_c1", 64'(f_ack0), 64'd0);
      tick();
      chk("f_rd_c2",    64'(mem_rd0), 64'd1);
      mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      chk("f_rd_off",   64'(mem_rd0), 64'd0);
      chk("f_ack",      64'(f_ack0), 64'd1);
      chk("f_rdata",    64'(f_rdata0), 64'hDEADBEEF);
      chk("f_no_dack",  64'({d_ack0, bus_err0}), 64'd0);
      mem_ready = 1'b0; f_req = 1'b0;
      tick();
      chk("f_ack_pulse", 64'(f_ack0), 64'd0);
      chk("f_rdata_hold", 64'(f_rdata0), 64'hDEADBEEF);

      // D store, ready in the first strobe cycle
      d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 32'h0000_1234;
      tick();
      chk("st_wr",    64'(mem_wr0), 64'd1);
      chk("st_rd",    64'(mem_rd0), 64'd0);
      chk("st_addr",  64'(mem_addr0), 64'h0020);
      chk("st_wdata", 64'(mem_wdata0), 64'h1234);
      mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
      tick();
      chk("st_wr_off",  64'(mem_wr0), 64'd0);
      chk("st_dack",    64'(d_ack0), 64'd1);
      chk("st_no_fack", 64'(f_ack0), 64'd0);
      chk("st_drdata",  64'(d_rdata0), 64'd0);
      mem_ready = 1'b0; d_req = 1'b0; d_wr = 1'b0;
      tick();
      chk("st_dack_pulse", 64'(d_ack0), 64'd0);

      // Conflict: u0 alternates F,D,F,D; u1 always picks D
      exp_d0 = 4'b1010;
      f_req = 1'b1; f_addr = 16'h0100;
      d_req = 1'b1; d_addr = 16'h0200;
      for (int k = 0; k < 4; k++) begin
         tick();
         exp_addr = exp_d0[k] ? 16'h0200 : 16'h0100;
         chk($sformatf("rr_addr%0d", k), 64'(mem_addr0), 64'(exp_addr));
         chk($sformatf("rr_rd%0d", k), 64'(mem_rd0), 64'd1);
         chk($sformatf("rr_early_ack%0d", k), 64'({f_ack0, d_ack0}), 64'd0);
         chk($sformatf("pr_addr%0d", k), 64'(mem_addr1), 64'h0200);
         rd = 32'hA000_0000 + 32'(k);
         mem_ready = 1'b1; mem_rdata = rd;
         tick();
         chk($sformatf("rr_ack%0d", k), 64'({f_ack0, d_ack0}), exp_d0[k] ? 64'd1 : 64'd2);
         if (exp_d0[k]) chk($sformatf("rr_drdata%0d", k), 64'(d_rdata0), 64'(rd));
         else           chk($sformatf("rr_frdata%0d", k), 64'(f_rdata0), 64'(rd));
         chk($sformatf("pr_ack%0d", k), 64'({f_ack1, d_ack1}), 64'd1);
         chk($sformatf("pr_drdata%0d", k), 64'(d_rdata1), 64'(rd));
         mem_ready = 1'b0;
         if (k == 3) d_req = 1'b0;
         tick();
      end

      // D-priority port serves F once D stops requesting
      tick();
      chk("pr_f_addr", 64'(mem_addr1), 64'h0100);
      chk("pr_f_rd",   64'(mem_rd1), 64'd1);
      mem_ready = 1'b1; mem_rdata = 32'hB0B0B0B0;
      tick();
      chk("pr_f_ack",   64'(f_ack1), 64'd1);
      chk("pr_f_rdata", 64'(f_rdata1), 64'hB0B0B0B0);
      mem_ready = 1'b0; f_req = 1'b0;
      tick();

      // Ready in the last watchdog cycle wins over the abort
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("rw_rd%0d", i), 64'(mem_rd0), 64'd1);
      end
      mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      chk("rw_ack",    64'(d_ack0), 64'd1);
      chk("rw_no_err", 64'(bus_err0), 64'd0);
      chk("rw_rdata",  64'(d_rdata0), 64'h1234_5678);
      mem_ready = 1'b0; d_req = 1'b0;
      tick();

      // Watchdog abort: strobe 4 cycles, ack with bus_err, rdata forced to 0
      d_req = 1'b1; d_addr = 16'h0030; mem_rdata = 32'h5555_5555;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("to_rd%0d", i), 64'(mem_rd0), 64'd1);
      end
      tick();
      chk("to_rd_off", 64'(mem_rd0), 64'd0);
      chk("to_ack",    64'(d_ack0), 64'd1);
      chk("to_err",    64'(bus_err0), 64'd1);
      chk("to_rdata",  64'(d_rdata0), 64'd0);
      chk("nowd_busy", 64'(mem_rd1), 64'd1);
      d_req = 1'b0;
      tick();
      chk("to_pulse", 64'({d_ack0, bus_err0}), 64'd0);

      // Reset in the middle of BUSY, then first conflict after release
      f_req = 1'b1; f_addr = 16'h0100;
      tick();
      chk("mr_rd_before", 64'(mem_rd0), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_strb0", 64'({mem_rd0, mem_wr0, f_ack0, d_ack0, bus_err0}), 64'd0);
      chk("mr_strb1", 64'({mem_rd1, mem_wr1, f_ack1, d_ack1, bus_err1}), 64'd0);
      tick();
      rst_n = 1'b1;
      f_req = 1'b1; f_addr = 16'h0100;
      d_req = 1'b1; d_addr = 16'h0200; d_wr = 1'b0;
      tick();
      chk("mr_rr_first", 64'(mem_addr0), 64'h0100);
      chk("mr_rr_rd",    64'(mem_rd0), 64'd1);
      chk("mr_pr_first", 64'(mem_addr1), 64'h0200);
      f_req = 1'b0; d_req = 1'b0;
      mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
      tick();
      chk("mr_rr_ack", 64'(f_ack0), 64'd1);
      mem_ready = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
